// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,  // reserved when parity is not built in
    STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. A synchronous clear holds it at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Advance once per clock, wrapping at the last cycle of the bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even
// parity, one stop bit. Each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: UART_TX_PARITY_EN inserts the even-parity bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  uart_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              bit_clr;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  // The bit timer is idle-cleared so every frame starts on a fresh period;
  // between bits it wraps on its own, which restarts it on each state entry.
  assign bit_clr = reset || (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk (clk),
    .clr (bit_clr),
    .tick(tick)
  );

  assign shreg_shift = shreg >> 1;
  assign tx_ready    = (state == IDLE);
  assign tx_busy     = (state != IDLE);
  assign tx_done     = (state == STOP) && tick;

  // Frame sequencer; txd is registered alongside the state so the line
  // level always matches the state being held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      txd   <= UART_IDLE_LVL;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state <= START;
            txd   <= UART_START_LVL;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= par;
`else
              state <= STOP;
              txd   <= UART_STOP_LVL;
`endif
            end else begin
              txd <= shreg_shift[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= UART_STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            txd   <= UART_IDLE_LVL;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= UART_IDLE_LVL;
        end
      endcase
    end
  end

  // Byte capture at the handshake, then shift-out during DATA; these
  // registers carry payload only and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && tx_valid) begin
      shreg <= tx_data;
`ifdef UART_TX_PARITY_EN
      par   <= ^tx_data;
`endif
    end else if (state == DATA && tick && idx != LAST_IDX) begin
      shreg <= shreg_shift;
    end
  end

  // Data bit index: restarted on entry to DATA, stepped per bit.
  always_ff @(posedge clk) begin
    if (state == START) begin
      idx <= '0;
    end else if (state == DATA && tick && idx != LAST_IDX) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLKS_PER_BIT=4, DATA_W=8.
// Build with UART_TX_PARITY_EN to exercise the parity frame.
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = CPB * NBITS;

  logic          clk;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic          tx_done;

  int n_assert;
  int n_fail;

  uart_tx_frame #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit position p of byte b.
  function automatic logic frame_bit(input logic [DW-1:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= DW) return b[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge: present a byte and let the next posedge accept it.
  task automatic accept(input logic [DW-1:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    check("ready_at_accept", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Checks a whole frame after acceptance, then the single idle gap cycle.
  // hold/nd: tx_valid/tx_data applied on the first cycle after acceptance.
  // pulse_at: cycle at which a one-cycle 0x5A offer is made mid-frame.
  task automatic run_frame(input logic [DW-1:0] b, input logic hold,
                           input logic [DW-1:0] nd, input int pulse_at);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tx_valid = hold;
        tx_data  = nd;
      end
      if (pulse_at != 0 && k == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        check($sformatf("ready_busy_%02h_k%0d", b, k), {31'd0, tx_ready}, 32'd0);
      end
      if (pulse_at != 0 && k == pulse_at + 1) begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
      check($sformatf("txd_%02h_k%0d", b, k), {31'd0, txd}, {31'd0, frame_bit(b, (k - 1) / CPB)});
      check($sformatf("busy_%02h_k%0d", b, k), {31'd0, tx_busy}, 32'd1);
      check($sformatf("done_%02h_k%0d", b, k), {31'd0, tx_done}, (k == FRAME) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check($sformatf("gap_txd_%02h", b), {31'd0, txd}, 32'd1);
    check($sformatf("gap_busy_%02h", b), {31'd0, tx_busy}, 32'd0);
    check($sformatf("gap_ready_%02h", b), {31'd0, tx_ready}, 32'd1);
    check($sformatf("gap_done_%02h", b), {31'd0, tx_done}, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("idle_txd", {31'd0, txd}, 32'd1);

    // 1: single frame 0xA5
    accept(8'hA5);
    run_frame(8'hA5, 1'b0, 8'h00, 0);

    // 2: back-to-back 0x00 then 0xFF with tx_valid held
    accept(8'h00);
    run_frame(8'h00, 1'b1, 8'hFF, 0);
    run_frame(8'hFF, 1'b0, 8'h00, 0);

    // 3: 0x5A offered mid-frame of 0x11 is ignored
    accept(8'h11);
    run_frame(8'h11, 1'b0, 8'h00, 9);
    @(negedge clk);
    check("no_5a_txd", {31'd0, txd}, 32'd1);
    check("no_5a_busy", {31'd0, tx_busy}, 32'd0);

    // 4: reset during data bit 3 of 0xC3, then 0x3C
    accept(8'hC3);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      check($sformatf("txd_c3_k%0d", k), {31'd0, txd}, {31'd0, frame_bit(8'hC3, (k - 1) / CPB)});
      check($sformatf("done_c3_k%0d", k), {31'd0, tx_done}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_done", {31'd0, tx_done}, 32'd0);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("post_abort_txd", {31'd0, txd}, 32'd1);
    accept(8'h3C);
    run_frame(8'h3C, 1'b0, 8'h00, 0);

`ifdef UART_TX_PARITY_EN
    // 5: parity frames
    check("par_a5_model", {31'd0, frame_bit(8'hA5, DW + 1)}, 32'd0);
    check("par_07_model", {31'd0, frame_bit(8'h07, DW + 1)}, 32'd1);
    accept(8'hA5);
    run_frame(8'hA5, 1'b0, 8'h00, 0);
    accept(8'h07);
    run_frame(8'h07, 1'b0, 8'h00, 0);
`endif

    // 6: tx_data changed to 0xFF right after accepting 0x81
    accept(8'h81);
    run_frame(8'h81, 1'b0, 8'hFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
